// File: rtl/ahb_lite_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module : ahb_lite_mem_slave_if
// Desc   : AHB-Lite bus bundle between a fabric master and the memory slave.
// Rev    : 1.0
// ============================================================================
interface ahb_lite_mem_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : ahb_lite_mem_slave
// Desc   : AHB-Lite register-memory responder with wait states, two-cycle
//          ERROR response and a registered fabric-side read port.
// Rev    : 1.0
// ============================================================================
module ahb_lite_mem_slave #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  wire                      HCLK,
    input  wire                      reset,
    ahb_lite_mem_slave_if.slave      bus,
    input  wire  [$clog2(DEPTH)-1:0] usr_raddr,
    output logic [31:0]              usr_rdata
);
    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] C_MEM_BYTES = 32'(DEPTH * 4);
    localparam logic [2:0]  C_WAIT      = 3'(WAIT_STATES);
    localparam bit          C_HAS_WAIT  = (WAIT_STATES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt;
    logic [31:0]      r_mem [DEPTH];
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_be;
    logic             r_wr_pend;
    logic             r_rd_pend;
    logic [31:0]      r_hrdata;

    logic             w_hreadyout;
    logic [1:0]       w_hresp;
    logic             w_accept;
    logic             w_err;
    logic             w_commit;
    logic             w_rd_late;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_fwd;

    always_comb begin
        w_offset = bus.HADDR - BASE_ADDR;
        w_idx    = w_offset[IDX_W+1:2];
        case (bus.HSIZE)
            3'b000:  w_be = 4'b0001 << bus.HADDR[1:0];
            3'b001:  w_be = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds
        w_err = (bus.HSIZE > 3'b010)
             || (w_offset >= C_MEM_BYTES)
             || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
             || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
    end

    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = 2'b00;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_hreadyout = (r_cnt == 3'd0);
                if (r_cnt != 3'd0) w_cnt_nxt = r_cnt - 3'd1;
                else               w_state_nxt = S_IDLE;
            end
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 2'b01;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                w_hresp     = 2'b01;
                w_state_nxt = S_IDLE;
            end
            default: ;
        endcase
        w_accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && w_hreadyout;
        if (w_accept) begin
            if (w_err) begin
                w_state_nxt = S_ERR1;
            end else if (C_HAS_WAIT) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = C_WAIT;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
        w_commit  = r_wr_pend && w_hreadyout;
        w_rd_late = C_HAS_WAIT && (r_state == S_WAIT) && (r_cnt == 3'd1) && r_rd_pend;
    end

    // A zero-wait read accepted while a write commits must see the new bytes
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_fwd[8*b +: 8] = (w_commit && (r_idx == w_idx) && r_be[b])
                            ? bus.HWDATA[8*b +: 8] : r_mem[w_idx][8*b +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_idx     <= '0;
            r_be      <= 4'b0000;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_hrdata  <= 32'd0;
            usr_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx     <= w_idx;
                r_be      <= w_be;
                r_wr_pend <= !w_err && bus.HWRITE;
                r_rd_pend <= !w_err && !bus.HWRITE;
            end else if (w_hreadyout) begin
                r_wr_pend <= 1'b0;
                r_rd_pend <= 1'b0;
            end
            if (w_accept && w_err)
                r_hrdata <= 32'd0;
            else if (w_accept && !bus.HWRITE && !C_HAS_WAIT)
                r_hrdata <= w_fwd;
            else if (w_rd_late)
                r_hrdata <= r_mem[r_idx];
            usr_rdata <= r_mem[usr_raddr];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!reset && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    assign bus.HREADYOUT = w_hreadyout;
    assign bus.HRESP     = w_hresp;
    assign bus.HRDATA    = r_hrdata;
endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_ahb_lite_mem_slave
// Desc   : Directed bench for the AHB-Lite memory slave, zero- and 3-wait builds.
// Rev    : 1.0
// ============================================================================
module tb_ahb_lite_mem_slave;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        tgt    = 1'b0;
    logic        hsel   = 1'b0;
    logic [31:0] haddr  = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize  = 3'b000;
    logic [31:0] hwdata = 32'd0;
    logic [4:0]  usr_raddr = 5'd0;
    logic [31:0] urd0, urd3;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdat;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ahb_lite_mem_slave_if if0();
    ahb_lite_mem_slave_if if3();

    assign if0.HSEL   = hsel & ~tgt;
    assign if0.HADDR  = haddr;
    assign if0.HTRANS = htrans;
    assign if0.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;
    assign if0.HBURST = 3'b000;
    assign if0.HWDATA = hwdata;
    assign if0.HREADY = if0.HREADYOUT;
    assign if3.HSEL   = hsel & tgt;
    assign if3.HADDR  = haddr;
    assign if3.HTRANS = htrans;
    assign if3.HWRITE = hwrite;
    assign if3.HSIZE  = hsize;
    assign if3.HBURST = 3'b001;
    assign if3.HWDATA = hwdata;
    assign if3.HREADY = if3.HREADYOUT;

    assign rdy  = tgt ? if3.HREADYOUT : if0.HREADYOUT;
    assign resp = tgt ? if3.HRESP     : if0.HRESP;
    assign rdat = tgt ? if3.HRDATA    : if0.HRDATA;

    ahb_lite_mem_slave #(.DEPTH(32), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
        .HCLK(clk), .reset(reset), .bus(if0), .usr_raddr(usr_raddr), .usr_rdata(urd0));
    ahb_lite_mem_slave #(.DEPTH(32), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut3 (
        .HCLK(clk), .reset(reset), .bus(if3), .usr_raddr(usr_raddr), .usr_rdata(urd3));

    // Single non-pipelined transfer; starts and ends 1ns after a rising edge
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic [1:0] rs, output int lowcnt, output logic tmo);
        hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        lowcnt = 0; tmo = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy) break;
            lowcnt++;
            if (lowcnt > 20) begin tmo = 1'b1; break; end
        end
        rd = rdat; rs = resp;
        @(posedge clk); #1;
    endtask

    // Write address phase immediately followed by a read address phase (zero-wait slave)
    task automatic b2b(input logic [31:0] waddr, input logic [2:0] wsize, input logic [31:0] wdata,
                       input logic [31:0] raddr, output logic [31:0] rd, output logic r_o,
                       output logic [1:0] rs, output logic [31:0] u_old);
        hsel = 1'b1; haddr = waddr; htrans = 2'b10; hwrite = 1'b1; hsize = wsize;
        @(posedge clk); #1;
        haddr = raddr; hwrite = 1'b0; hsize = 3'b010; hwdata = wdata;
        @(posedge clk); #1;
        u_old = urd0;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        rd = rdat; r_o = rdy; rs = resp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (if0.HREADYOUT !== 1'b1) begin n_errors++; $display("FAIL reset_hreadyout: got %b expected 1", if0.HREADYOUT); end
        n_checks++; if (if0.HRESP !== 2'b00) begin n_errors++; $display("FAIL reset_hresp: got %b expected 00", if0.HRESP); end
        n_checks++; if (if0.HRDATA !== 32'd0) begin n_errors++; $display("FAIL reset_hrdata: got %h expected 0", if0.HRDATA); end
        n_checks++; if (urd0 !== 32'd0) begin n_errors++; $display("FAIL reset_usr_rdata: got %h expected 0", urd0); end
        n_checks++; if (if3.HREADYOUT !== 1'b1) begin n_errors++; $display("FAIL reset_hreadyout_ws3: got %b expected 1", if3.HREADYOUT); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic [1:0] rs; int lc; logic to;
        tgt = 1'b0;
        xfer(1'b1, BASE + 32'h4, 3'b010, 32'hDEAD_BEEF, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b00 || lc !== 0 || to) begin n_errors++; $display("FAIL word_write_resp: got resp %b waits %0d expected 00/0", rs, lc); end
        xfer(1'b0, BASE + 32'h4, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b00 || lc !== 0 || to) begin n_errors++; $display("FAIL word_read_resp: got resp %b waits %0d expected 00/0", rs, lc); end
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL word_read_data: got %h expected deadbeef", rd); end
        usr_raddr = 5'd1;
        @(posedge clk); #1;
        n_checks++; if (urd0 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL usr_rdata: got %h expected deadbeef", urd0); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic [1:0] rs; int lc; logic to;
        tgt = 1'b0;
        xfer(1'b1, BASE + 32'h6, 3'b000, 32'h5A5A_5A5A, rd, rs, lc, to);
        xfer(1'b0, BASE + 32'h4, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rd !== 32'hDE5A_BEEF) begin n_errors++; $display("FAIL byte_write: got %h expected de5abeef", rd); end
        xfer(1'b1, BASE + 32'h4, 3'b001, 32'h1111_C0DE, rd, rs, lc, to);
        xfer(1'b0, BASE + 32'h4, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rd !== 32'hDE5A_C0DE) begin n_errors++; $display("FAIL half_write: got %h expected de5ac0de", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, uo; logic [1:0] rs; int lc; logic to, r;
        tgt = 1'b0;
        xfer(1'b1, BASE + 32'h8, 3'b010, 32'h1111_1111, rd, rs, lc, to);
        usr_raddr = 5'd2;
        b2b(BASE + 32'h8, 3'b010, 32'h1234_5678, BASE + 32'h8, rd, r, rs, uo);
        n_checks++; if (rd !== 32'h1234_5678 || r !== 1'b1 || rs !== 2'b00) begin n_errors++; $display("FAIL b2b_word: got %h rdy %b resp %b expected 12345678/1/00", rd, r, rs); end
        n_checks++; if (uo !== 32'h1111_1111) begin n_errors++; $display("FAIL usr_same_edge: got %h expected 11111111", uo); end
        n_checks++; if (urd0 !== 32'h1234_5678) begin n_errors++; $display("FAIL usr_next_cycle: got %h expected 12345678", urd0); end
        b2b(BASE + 32'h8, 3'b000, 32'hAAAA_AAAA, BASE + 32'h8, rd, r, rs, uo);
        n_checks++; if (rd !== 32'h1234_56AA) begin n_errors++; $display("FAIL b2b_byte: got %h expected 123456aa", rd); end
        b2b(BASE + 32'hA, 3'b001, 32'hBEEF_0000, BASE + 32'h8, rd, r, rs, uo);
        n_checks++; if (rd !== 32'hBEEF_56AA) begin n_errors++; $display("FAIL b2b_half: got %h expected beef56aa", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] rs; int lc; logic to;
        tgt = 1'b0;
        xfer(1'b0, BASE + 32'h2, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b01 || lc !== 1 || to) begin n_errors++; $display("FAIL err_misalign: got resp %b low %0d expected 01/1", rs, lc); end
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL err_hrdata: got %h expected 0", rd); end
        n_checks++; if (rdy !== 1'b1 || resp !== 2'b00) begin n_errors++; $display("FAIL err_to_idle: got rdy %b resp %b expected 1/00", rdy, resp); end
        xfer(1'b0, BASE + 32'h80, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b01 || lc !== 1 || to) begin n_errors++; $display("FAIL err_range: got resp %b low %0d expected 01/1", rs, lc); end
        xfer(1'b1, BASE - 32'h4, 3'b010, 32'hFFFF_FFFF, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b01) begin n_errors++; $display("FAIL err_below_base: got resp %b expected 01", rs); end
        xfer(1'b1, BASE + 32'h6, 3'b010, 32'hFFFF_FFFF, rd, rs, lc, to);
        xfer(1'b1, BASE + 32'h4, 3'b011, 32'hFFFF_FFFF, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b01) begin n_errors++; $display("FAIL err_size: got resp %b expected 01", rs); end
        xfer(1'b1, BASE + 32'h5, 3'b001, 32'hFFFF_FFFF, rd, rs, lc, to);
        n_checks++; if (rs !== 2'b01) begin n_errors++; $display("FAIL err_half_misalign: got resp %b expected 01", rs); end
        xfer(1'b0, BASE + 32'h4, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rd !== 32'hDE5A_C0DE || rs !== 2'b00) begin n_errors++; $display("FAIL err_no_write: got %h resp %b expected de5ac0de/00", rd, rs); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic [1:0] rs; int lc; logic to;
        tgt = 1'b1;
        xfer(1'b1, BASE + 32'h10, 3'b010, 32'hA5A5_0F0F, rd, rs, lc, to);
        n_checks++; if (lc !== 3 || rs !== 2'b00 || to) begin n_errors++; $display("FAIL ws_write: got low %0d resp %b expected 3/00", lc, rs); end
        xfer(1'b0, BASE + 32'h10, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (lc !== 3 || rs !== 2'b00 || to) begin n_errors++; $display("FAIL ws_read: got low %0d resp %b expected 3/00", lc, rs); end
        n_checks++; if (rd !== 32'hA5A5_0F0F) begin n_errors++; $display("FAIL ws_read_data: got %h expected a5a50f0f", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic [1:0] rs; int lc; logic to;
        tgt = 1'b1;
        hsel = 1'b1; haddr = BASE + 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0000;
        n_checks++; if (if3.HREADYOUT !== 1'b0) begin n_errors++; $display("FAIL mid_wait_low: got %b expected 0", if3.HREADYOUT); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (if3.HREADYOUT !== 1'b1 || if3.HRESP !== 2'b00) begin n_errors++; $display("FAIL reset_abort: got rdy %b resp %b expected 1/00", if3.HREADYOUT, if3.HRESP); end
        reset = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'h10, 3'b010, 32'd0, rd, rs, lc, to);
        n_checks++; if (rd !== 32'hA5A5_0F0F || to) begin n_errors++; $display("FAIL reset_no_commit: got %h expected a5a50f0f", rd); end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_wait_states();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite responder (slave) on the FIC_0 fabric bus: the other end of the fabric AHB master interface.
- Holds a DEPTH x 32-bit register memory that the HPMS or a fabric master can write and read.
- Supports byte, halfword and word accesses, programmable wait states, and a two-cycle ERROR response.
- A separate fabric-side read port lets downstream logic (SPI, TPSRAM loaders) read the memory without bus arbitration.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, 2..256.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; 0..7.
- BASE_ADDR, 32'h3000_0000, address of word 0; DEPTH*4-aligned.

Ports:
- HCLK  in  1  bus clock (FIC_0_CLK); all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBURST  in  3  accepted and ignored; every beat is decoded independently.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; qualifies the address phase.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  2  00 OKAY, 01 ERROR.
- usr_raddr  in  log2(DEPTH)  fabric read word index.
- usr_rdata  out  32  registered memory[usr_raddr], 1-cycle latency.

Behaviour:
- Reset (synchronous, active-high):
  - HREADYOUT=1, HRESP=00, HRDATA=0, usr_rdata=0, state=IDLE.
  - Memory contents are NOT cleared.
  - Reset asserted mid-transfer abandons that transfer with no write commit; the first cycle after reset deasserts is IDLE.
- Address phase accept: HSEL & HREADY & HTRANS[1] on a rising edge.
  - Latch HADDR, HWRITE and HSIZE.
  - IDLE or BUSY, or HSEL=0, gets a zero-wait OKAY with no side effects.
- Error decode on the latched address phase. ERROR is returned if any of these holds:
  - HSIZE > 010;
  - HADDR outside BASE_ADDR .. BASE_ADDR+DEPTH*4-1;
  - misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]≠00.
- State machine: IDLE, WAIT, ERR1, ERR2.
  - IDLE, accept OK, WAIT_STATES=0 -> stay IDLE; data phase completes next cycle with HREADYOUT=1.
  - IDLE, accept OK, WAIT_STATES>0 -> WAIT. Counter loads WAIT_STATES and HREADYOUT=0 until it reaches 0; then HREADYOUT=1 for exactly one cycle and state returns to IDLE.
  - IDLE, accept error -> ERR1 (HRESP=01, HREADYOUT=0) -> ERR2 (HRESP=01, HREADYOUT=1) -> IDLE. No memory write occurs.
  - A new address phase is accepted on the same edge a data phase completes (pipelined back-to-back, HREADY=1). No address phase is accepted while HREADYOUT=0.
- Writes:
  - Commit at the completing edge of the data phase, using HWDATA sampled at that edge.
  - Little-endian byte lanes: byte lane = HADDR[1:0]; halfword lanes = HADDR[1]. Unaddressed bytes are unchanged.
- Reads:
  - HRDATA carries the full 32-bit word at the latched index, valid whenever HREADYOUT=1 in an OKAY read data phase.
  - HRDATA holds its last value otherwise; during ERROR it is 0.
- Read-after-write:
  - A read whose address phase overlaps the data phase of a write to the same word returns the newly written bytes.
  - Lanes not written by that write return the old contents.
- Word index = (HADDR-BASE_ADDR)>>2. No wrap; out-of-range addresses raise ERROR.
- usr_rdata: a usr_raddr read on the same edge as a bus write to the same word returns the old value; the new value appears the next cycle.

Test Plan:
- Reset, then word write 0xDEADBEEF to BASE+0x04, then read BASE+0x04, WAIT_STATES=0 -> OKAY, zero waits, HRDATA=0xDEADBEEF; usr_raddr=1 gives usr_rdata=0xDEADBEEF one cycle later.
- Byte write 0x5A to BASE+0x06 over 0xDEADBEEF -> subsequent word read of BASE+0x04 returns 0xDE5ABEEF.
- Back-to-back write 0x12345678 to BASE+0x08 then read BASE+0x08 (pipelined, no idle between) -> HRDATA=0x12345678.
- Word read at BASE+0x02 (misaligned), then separately a read at BASE+DEPTH*4 (out of range) -> each gives HRESP=01 with HREADYOUT 0 then 1, then IDLE; memory unchanged.
- WAIT_STATES=3, write then read -> HREADYOUT low exactly 3 cycles per transfer; data correct.
- reset asserted during a WAIT-state write -> next cycle HREADYOUT=1, HRESP=00; target word still holds its pre-write value.
